// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared constants and types for the multi-ported register file slice.
//   XLEN_DEF / NREGS_DEF are the default data width and register count.
//   reg_addr_t is the register-address type for the default register count.
//   Optional feature macro used by reg_file_mp: REG_FILE_BYPASS_EN.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Busy-bit scoreboard for the register file. A register becomes busy when
//   an instruction writing it issues, and is released when its write commits.
//   Register 0 is never busy. busy_cnt is a registered population count of
//   the busy bits, updated on the same edge as the bits themselves.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   iss_valid issue strobe, iss_addr is the destination register
//   iss_addr  destination register of the issued instruction
//   clr       one bit per register, set for registers committed this cycle
//   busy      current busy bit per register
//   busy_cnt  number of registers currently busy
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  input  logic [NREGS-1:0] clr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  logic [NREGS-1:0] setVec;
  logic [NREGS-1:0] busyNext;
  logic [AW:0]      cntNext;

  // The set is OR-ed in after the clear so that an issue and a commit to the
  // same register in one cycle leaves it busy (the new producer is pending).
  always_comb begin
    setVec = '0;
    if (iss_valid && (iss_addr != '0)) begin
      setVec[iss_addr] = 1'b1;
    end
    busyNext    = (busy & ~clr) | setVec;
    busyNext[0] = 1'b0;
    cntNext     = '0;
    for (int k = 0; k < NREGS; k++) begin
      cntNext = cntNext + {{AW{1'b0}}, busyNext[k]};
    end
  end

  // Count is taken from the next-state vector so it tracks busy exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busyNext;
      busy_cnt <= cntNext;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
//   Multi-ported register file with combinational reads, clocked writes and
//   an issue/commit busy scoreboard. Register 0 reads as zero, ignores writes
//   and is never busy. When several write ports hit the same register in one
//   cycle, the highest-indexed port wins.
//   Optional macro REG_FILE_BYPASS_EN: a read matching an active write in the
//   same cycle returns that write's data (highest matching port) and reports
//   rbusy=0. Without it, rdata/rbusy reflect stored state only.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   raddr      NRD read addresses, port i at [i*AW +: AW]
//   rdata      NRD read data words, port i at [i*XLEN +: XLEN]
//   rbusy      per read port, addressed register has a pending write
//   we         per write port enable
//   waddr      NWR write addresses
//   wdata      NWR write data words
//   iss_valid  issue of an instruction writing iss_addr
//   iss_addr   destination of the issued instruction
//   busy_cnt   number of busy registers
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] clrVec;
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    wa;
  logic [AW-1:0]    ra;
  logic [XLEN-1:0]  rd;
  logic             rb;
`ifdef REG_FILE_BYPASS_EN
  logic [AW-1:0]    ba;
`endif

  // Ports are visited in ascending order, so the last non-blocking update to
  // a shared address (highest port index) is the one that sticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != '0)) begin
          regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Registers whose write commits this cycle; they release their busy bit.
  always_comb begin
    clrVec = '0;
    wa     = '0;
    for (int j = 0; j < NWR; j++) begin
      wa = waddr[j*AW +: AW];
      if (we[j] && (wa != '0)) begin
        clrVec[wa] = 1'b1;
      end
    end
  end

  // Read muxing; address 0 is forced to zero/not-busy last so that neither
  // storage nor bypass can leak a value for it.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    ba    = '0;
`endif
    for (int i = 0; i < NRD; i++) begin
      ra = raddr[i*AW +: AW];
      rd = regs[ra];
      rb = busy[ra];
`ifdef REG_FILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        ba = waddr[j*AW +: AW];
        if (we[j] && (ba == ra)) begin
          rd = wdata[j*XLEN +: XLEN];
          rb = 1'b0;
        end
      end
`endif
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
      rdata[i*XLEN +: XLEN] = rd;
      rbusy[i]              = rb;
    end
  end

  reg_file_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .clr       (clrVec),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
//   Self-checking bench for reg_file_mp (XLEN=32, NREGS=32, NRD=2, NWR=2).
//   A behavioural model (plain arrays) predicts rdata/rbusy/busy_cnt and a
//   compare process checks them every cycle; directed sequences pin the model
//   with literal expectations. Honours REG_FILE_BYPASS_EN when defined.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        iss_valid;
  reg_addr_t   iss_addr;
  logic [5:0]  busy_cnt;

  int vectors     = 0;
  int miscompares = 0;
  logic checkEn = 1'b0;

  logic [31:0] mMem  [32];
  bit          mBusy [32];

  reg_file_mp #(
    .XLEN  (32),
    .NREGS (32),
    .NRD   (2),
    .NWR   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < 32; k++) begin
      mMem[k]  = '0;
      mBusy[k] = 1'b0;
    end
  endfunction

  // Expected read value: stored value, optionally overridden by a same-cycle
  // write (highest port last), and always zero for x0.
  function automatic logic [31:0] expData(input logic [4:0] a);
    logic [31:0] v;
    v = mMem[a];
`ifdef REG_FILE_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (we[j] && waddr[j*5 +: 5] == a) v = wdata[j*32 +: 32];
`endif
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    logic b;
    b = mBusy[a];
`ifdef REG_FILE_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (we[j] && waddr[j*5 +: 5] == a) b = 1'b0;
`endif
    if (a == 5'd0) b = 1'b0;
    return b;
  endfunction

  function automatic int expCount();
    int c = 0;
    for (int k = 0; k < 32; k++) c += int'(mBusy[k]);
    return c;
  endfunction

  always @(negedge reset_n) modelReset();

  // Model state update at each active edge while out of reset.
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && waddr[j*5 +: 5] != 5'd0) begin
          mMem[waddr[j*5 +: 5]]  = wdata[j*32 +: 32];
          mBusy[waddr[j*5 +: 5]] = 1'b0;
        end
      end
      if (iss_valid && iss_addr != 5'd0) mBusy[iss_addr] = 1'b1;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("rdata%0d", i), rdata[i*32 +: 32], expData(raddr[i*5 +: 5]));
        checkOutput($sformatf("rbusy%0d", i), {31'd0, rbusy[i]}, {31'd0, expBusy(raddr[i*5 +: 5])});
      end
      checkOutput("busy_cnt", {26'd0, busy_cnt}, 32'(expCount()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = '0;
    iss_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      we = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        waddr[j*5 +: 5] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
        wdata[j*32 +: 32] = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(0, 31));
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 2) == 0) raddr[i*5 +: 5] = waddr[($urandom_range(0, 1))*5 +: 5];
        else raddr[i*5 +: 5] = 5'($urandom_range(0, 31));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    modelReset();
    reset_n   = 1'b0;
    raddr     = '0;
    we        = '0;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    checkEn = 1'b1;

    // Reset state across all addresses.
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      checkOutput("rst_rdata0", rdata[31:0], 32'h0);
      checkOutput("rst_rdata1", rdata[63:32], 32'h0);
      checkOutput("rst_rbusy", {30'd0, rbusy}, 32'h0);
      checkOutput("rst_cnt", {26'd0, busy_cnt}, 32'h0);
      tick();
    end

    // Basic write/read, and x0 discarding writes.
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
    tick();
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h00001234};
    raddr = {5'd5, 5'd5};
    #1;
    checkOutput("x5_read", rdata[31:0], 32'hDEADBEEF);
    tick();
    idle();
    raddr = {5'd5, 5'd0};
    #1;
    checkOutput("x0_read", rdata[31:0], 32'h0);
    checkOutput("x5_read_p1", rdata[63:32], 32'hDEADBEEF);

    // Two ports writing the same register: higher port wins.
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
    tick();
    idle();
    raddr = {5'd0, 5'd7};
    #1;
    checkOutput("x7_collide", rdata[31:0], 32'h22);

    // Scoreboard set, set-wins-over-clear, then clear.
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    idle();
    raddr = {5'd0, 5'd3};
    #1;
    checkOutput("x3_busy", {31'd0, rbusy[0]}, 32'h1);
    checkOutput("x3_cnt", {26'd0, busy_cnt}, 32'h1);
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33}; iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    idle();
    #1;
    checkOutput("x3_setwins", {31'd0, rbusy[0]}, 32'h1);
    checkOutput("x3_setwins_cnt", {26'd0, busy_cnt}, 32'h1);
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h34};
    tick();
    idle();
    #1;
    checkOutput("x3_clear", {31'd0, rbusy[0]}, 32'h0);
    checkOutput("x3_clear_cnt", {26'd0, busy_cnt}, 32'h0);

    // Same-cycle write/read of x9 with it busy.
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h77}; iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'hA5A5A5A5}; raddr = {5'd0, 5'd9};
    #1;
`ifdef REG_FILE_BYPASS_EN
    checkOutput("x9_bypass", rdata[31:0], 32'hA5A5A5A5);
    checkOutput("x9_bypass_busy", {31'd0, rbusy[0]}, 32'h0);
`else
    checkOutput("x9_nobypass", rdata[31:0], 32'h77);
    checkOutput("x9_nobypass_busy", {31'd0, rbusy[0]}, 32'h1);
`endif
    tick();
    idle();
    #1;
    checkOutput("x9_after", rdata[31:0], 32'hA5A5A5A5);
    checkOutput("x9_after_cnt", {26'd0, busy_cnt}, 32'h0);

    // Asynchronous reset mid-cycle.
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h55}; iss_valid = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    raddr = {5'd6, 5'd4};
    #1;
    checkOutput("x4_pre_rst", rdata[31:0], 32'h55);
    checkOutput("x6_busy_pre_rst", {31'd0, rbusy[1]}, 32'h1);
    checkOutput("cnt_pre_rst", {26'd0, busy_cnt}, 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("x4_in_rst", rdata[31:0], 32'h0);
    checkOutput("x6_busy_in_rst", {31'd0, rbusy[1]}, 32'h0);
    checkOutput("cnt_in_rst", {26'd0, busy_cnt}, 32'h0);
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h99}; iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    reset_n = 1'b1;
    #1;
    checkOutput("x4_ignored", rdata[31:0], 32'h0);
    checkOutput("cnt_ignored", {26'd0, busy_cnt}, 32'h0);
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    #1;
    checkOutput("x4_post_rst_busy", {31'd0, rbusy[0]}, 32'h1);

    // Randomized traffic against the model.
    applyStimulus(800);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count, power of two, >= 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 1, number of write ports.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 raddr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-009 rdata  output  NRD*XLEN  read data per port.
REQ-010 rbusy  output  NRD  per read port, addressed register has a pending write.
REQ-011 we  input  NWR  write enable per write port.
REQ-012 waddr  input  NWR*AW  write addresses.
REQ-013 wdata  input  NWR*XLEN  write data.
REQ-014 iss_valid  input  1  issue of an instruction that will write iss_addr.
REQ-015 iss_addr  input  AW  destination register of the issued instruction.
REQ-016 busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-017 Reads SHALL be combinational; rdata for address 0 SHALL always be 0.
REQ-018 Writes SHALL commit on rising clk when we[j]=1 and waddr[j]!=0; writes to register 0 SHALL be discarded.
REQ-019 Two write ports with the same address in one cycle: the highest-indexed port SHALL win.
REQ-020 Scoreboard: iss_valid=1 with iss_addr!=0 SHALL set busy[iss_addr] at the next edge.
REQ-021 A committed write SHALL clear busy[waddr] at the next edge.
REQ-022 Set and clear of the same register in one cycle: set SHALL win, so busy stays 1.
REQ-023 Issue to a register already busy: busy SHALL remain 1; no error is flagged.
REQ-024 Register 0 SHALL never be busy; rbusy SHALL be 0 for address 0.
REQ-025 busy_cnt SHALL be a registered population count of busy[], updated on the same edge as busy[].
REQ-026 Without bypass, a write SHALL be visible on rdata one cycle after the write edge.

Reset
REQ-027 reset_n=0 SHALL asynchronously clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-028 Writes or issues presented while reset_n=0 SHALL be ignored; the first edge after deassertion SHALL act normally.

Configuration
REQ-029 Macro REG_FILE_BYPASS_EN: when defined, a read whose address matches an active write in the same cycle SHALL return that wdata (highest-indexed matching port), with rbusy=0 for that port.
REQ-030 When REG_FILE_BYPASS_EN is undefined, rdata and rbusy SHALL reflect stored state only.

Structure
REQ-031 Package reg_file_pkg SHALL hold default XLEN/NREGS constants and the register-address typedef.
REQ-032 The busy bits and busy_cnt SHALL live in sub-module reg_file_scoreboard; storage and read muxing stay in reg_file_mp.

Verification
REQ-033 Reset, then read all 32 addresses on both ports -> rdata=0, rbusy=0, busy_cnt=0.
REQ-034 Write x5=0xDEADBEEF, read x5 next cycle -> 0xDEADBEEF; write x0=0x1234, read x0 -> 0.
REQ-035 NWR=2: both ports write x7 (0x11, 0x22) in one cycle -> x7 reads 0x22.
REQ-036 Issue x3, next cycle rbusy for x3=1, busy_cnt=1; write x3 with simultaneous issue x3 -> busy stays 1, busy_cnt=1; write x3 alone -> busy 0, busy_cnt=0.
REQ-037 With REG_FILE_BYPASS_EN, write x9=0xA5A5A5A5 while reading x9 same cycle -> rdata=0xA5A5A5A5, rbusy=0; without it -> old value.
REQ-038 Assert reset_n=0 mid-cycle after writing x4=0x55 and issuing x6 -> rdata=0 and busy_cnt=0 immediately, before the next edge.
